// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM 1-to-4 demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Modulo-NUM_SLOTS increment; NUM_SLOTS is a power of two so the add wraps.
  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return SLOT_W'(s + SLOT_W'(1));
  endfunction

endpackage

// File: rtl/tdm_frame_aligner.sv
// Hunt/lock alignment FSM: tracks the expected slot, flags alignment errors and
// tells the datapath which shadow register to load and when a frame completes.
module tdm_frame_aligner
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_sync,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_locked,
  output logic              o_sync_err,
  output logic              o_cap_c,
  output logic [SLOT_W-1:0] o_cap_idx_c,
  output logic              o_frame_done_c
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              r_sync_err;
  logic              w_sync_err_nxt;
  logic              r_locked;

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_slot     <= SLOT_FIRST;
      r_sync_err <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_sync_err <= w_sync_err_nxt;
      r_locked   <= (w_state_nxt == LOCKED);
    end
  end

  // Next-state, slot tracking and datapath strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = r_slot;
    w_sync_err_nxt = 1'b0;
    o_cap_c        = 1'b0;
    o_cap_idx_c    = r_slot;
    o_frame_done_c = 1'b0;

    if (i_valid) begin
      unique case (r_state)
        HUNT: begin
          if (i_sync) begin
            o_cap_c     = 1'b1;
            o_cap_idx_c = SLOT_FIRST;
            w_slot_nxt  = slot_inc(SLOT_FIRST);
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (i_sync) begin
            // Early sync restarts the frame at this beat.
            w_sync_err_nxt = (r_slot != SLOT_FIRST);
            o_cap_c        = 1'b1;
            o_cap_idx_c    = SLOT_FIRST;
            w_slot_nxt     = slot_inc(SLOT_FIRST);
          end else if (r_slot == SLOT_FIRST) begin
            w_sync_err_nxt = 1'b1;
            w_slot_nxt     = SLOT_FIRST;
            w_state_nxt    = HUNT;
          end else begin
            o_cap_c        = 1'b1;
            o_cap_idx_c    = r_slot;
            w_slot_nxt     = slot_inc(r_slot);
            o_frame_done_c = (r_slot == SLOT_LAST);
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_slot_nxt  = SLOT_FIRST;
        end
      endcase
    end
  end

  assign o_slot     = r_slot;
  assign o_locked   = r_locked;
  assign o_sync_err = r_sync_err;

endmodule

// File: rtl/tdm_demux_1to4.sv
// TDM 1-to-4 demultiplexer: collects four aligned slots in shadow registers and
// publishes them together on the four channel outputs once a frame completes.
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  output logic              frame_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err
);

  logic              w_cap_c;
  logic [SLOT_W-1:0] w_cap_idx_c;
  logic              w_frame_done_c;

  logic [WIDTH-1:0]  r_shadow0;
  logic [WIDTH-1:0]  r_shadow1;
  logic [WIDTH-1:0]  r_shadow2;
  logic [WIDTH-1:0]  r_out0;
  logic [WIDTH-1:0]  r_out1;
  logic [WIDTH-1:0]  r_out2;
  logic [WIDTH-1:0]  r_out3;
  logic              r_frame_valid;

  tdm_frame_aligner u_aligner (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (in_valid),
    .i_sync         (in_sync),
    .o_slot         (slot),
    .o_locked       (locked),
    .o_sync_err     (sync_err),
    .o_cap_c        (w_cap_c),
    .o_cap_idx_c    (w_cap_idx_c),
    .o_frame_done_c (w_frame_done_c)
  );

  // Shadow capture of slots 0..2; slot 3 goes straight to the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow0 <= '0;
      r_shadow1 <= '0;
      r_shadow2 <= '0;
    end else if (w_cap_c) begin
      unique case (w_cap_idx_c)
        SLOT_W'(0): r_shadow0 <= in_data;
        SLOT_W'(1): r_shadow1 <= in_data;
        SLOT_W'(2): r_shadow2 <= in_data;
        default:    ;
      endcase
    end
  end

  // Whole-frame output update; channels never change partially.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out0        <= '0;
      r_out1        <= '0;
      r_out2        <= '0;
      r_out3        <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_done_c;
      if (w_frame_done_c) begin
        r_out0 <= r_shadow0;
        r_out1 <= r_shadow1;
        r_out2 <= r_shadow2;
        r_out3 <= in_data;
      end
    end
  end

  assign out0        = r_out0;
  assign out1        = r_out1;
  assign out2        = r_out2;
  assign out3        = r_out3;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Bench for tdm_demux_1to4: queue-based frame model checked every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_tdm_demux_1to4;

  localparam int unsigned WIDTH = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_sync = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;

  tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .in_data     (in_data),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // Model: the beats gathered since the current frame began, as a queue.
  logic [WIDTH-1:0] q[$];
  bit               m_locked;
  bit               m_fv;
  bit               m_err;
  logic [WIDTH-1:0] m_out [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_locked = 1'b0;
      m_fv     = 1'b0;
      m_err    = 1'b0;
      for (int i = 0; i < 4; i++) m_out[i] = '0;
    end else begin
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (in_valid) begin
        if (!m_locked) begin
          if (in_sync) begin
            m_locked = 1'b1;
            q.delete();
            q.push_back(in_data);
          end
        end else if (in_sync) begin
          if (q.size() != 0) m_err = 1'b1;
          q.delete();
          q.push_back(in_data);
        end else if (q.size() == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          q.push_back(in_data);
          if (q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_out[i] = q[i];
            m_fv = 1'b1;
            q.delete();
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("out0", int'(out0), int'(m_out[0]));
    chk("out1", int'(out1), int'(m_out[1]));
    chk("out2", int'(out2), int'(m_out[2]));
    chk("out3", int'(out3), int'(m_out[3]));
    chk("frame_valid", int'(frame_valid), int'(m_fv));
    chk("sync_err", int'(sync_err), int'(m_err));
    chk("locked", int'(locked), int'(m_locked));
    chk("slot", int'(slot), q.size());
    chk("fv_and_err", int'(frame_valid & sync_err), 0);
    if (frame_valid) fv_cnt++;
  end

  // Apply one cycle of input; call at a negedge, returns at the next negedge.
  task automatic drive(input bit v, input bit s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
  endtask

  function automatic int outs();
    return {28'd0, out3, out2, out1, out0};
  endfunction

  initial begin
    int fv_base;
    logic [3:0] v;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", outs(), 0);
    chk("rst_locked", int'(locked), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(3);
    chk("post_rst_outs", outs(), 0);
    chk("post_rst_slot", int'(slot), 0);

    // Normal frame: out0..3 = 1,0,1,1
    drive(1, 1, 1'b1);
    chk("norm_locked", int'(locked), 1);
    chk("norm_slot1", int'(slot), 1);
    drive(1, 0, 1'b0);
    drive(1, 0, 1'b1);
    drive(1, 0, 1'b1);
    chk("norm_fv", int'(frame_valid), 1);
    chk("norm_outs", outs(), 4'b1101);
    chk("norm_slot0", int'(slot), 0);
    idle(1);
    chk("norm_fv_pulse", int'(frame_valid), 0);
    chk("norm_hold", outs(), 4'b1101);

    // Gapped frame: 1,1,0,0 with two idle cycles between beats
    drive(1, 1, 1'b1); idle(2);
    chk("gap_slot_hold", int'(slot), 1);
    drive(1, 0, 1'b1); idle(2);
    chk("gap_slot2", int'(slot), 2);
    chk("gap_no_fv", int'(frame_valid), 0);
    drive(1, 0, 1'b0); idle(2);
    drive(1, 0, 1'b0);
    chk("gap_fv", int'(frame_valid), 1);
    chk("gap_outs", outs(), 4'b0011);
    idle(2);

    // Early sync: restart frame at the third beat
    drive(1, 1, 1'b0);
    drive(1, 0, 1'b1);
    drive(1, 1, 1'b1);
    chk("early_err", int'(sync_err), 1);
    chk("early_no_fv", int'(frame_valid), 0);
    chk("early_slot", int'(slot), 1);
    chk("early_locked", int'(locked), 1);
    chk("early_hold", outs(), 4'b0011);
    drive(1, 0, 1'b0);
    chk("early_err_pulse", int'(sync_err), 0);
    drive(1, 0, 1'b0);
    drive(1, 0, 1'b1);
    chk("early_fv", int'(frame_valid), 1);
    chk("early_outs", outs(), 4'b1001);

    // Missing sync: unsynced beat at slot 0 drops lock
    drive(1, 0, 1'b1);
    chk("miss_err", int'(sync_err), 1);
    chk("miss_locked", int'(locked), 0);
    chk("miss_hold", outs(), 4'b1001);
    drive(1, 0, 1'b0);
    drive(1, 0, 1'b1);
    chk("hunt_no_err", int'(sync_err), 0);
    chk("hunt_slot", int'(slot), 0);
    idle(1);

    // Mid-frame reset discards partial frame and outputs
    drive(1, 1, 1'b1);
    drive(1, 0, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_outs", outs(), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_slot", int'(slot), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(2);
    chk("mid_rst_after", outs(), 0);

    // Back-to-back sweep of all 16 channel patterns
    fv_base = fv_cnt;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      drive(1, 1, v[0]);
      drive(1, 0, v[1]);
      drive(1, 0, v[2]);
      drive(1, 0, v[3]);
      chk("sweep_fv", int'(frame_valid), 1);
      chk("sweep_outs", outs(), k);
    end
    idle(2);
    chk("sweep_fv_count", fv_cnt - fv_base, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
